dbus_periph_router: RTL and testbench

Data-bus router between the LSU data-bus master and the memory-mapped slaves: boot memory (target 0), UART (target 1) and CLINT (target 2). It decodes each LSU request address and registers the request. It then drives a one-hot target select/request, holds it until that target acks, and returns the read data and ack to the LSU. Unmapped addresses and slaves that never respond are closed with an error ack, so the LSU never hangs.

---
 rtl/dbus_periph_router.sv | 145 ++++++++++++++
 tb/tb_dbus_periph_router.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_periph_router.sv
// Routes LSU data-bus requests to boot memory, UART or CLINT and returns ack/rdata.
// Unmapped addresses and unresponsive slaves are closed with an error ack.
module dbus_periph_router #(
   parameter logic [31:0] BMEM_BASE      = 32'h0001_0000,
   parameter logic [31:0] BMEM_MASK      = 32'hFFFF_0000,
   parameter logic [31:0] UART_BASE      = 32'h9000_0000,
   parameter logic [31:0] UART_MASK      = 32'hFFFF_FF00,
   parameter logic [31:0] CLINT_BASE     = 32'h0200_0000,
   parameter logic [31:0] CLINT_MASK     = 32'hFFFF_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lsu_req_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_wdata_i,
   input  logic        lsu_wen_i,
   input  logic [3:0]  lsu_sel_i,
   output logic [31:0] lsu_rdata_o,
   output logic        lsu_ack_o,
   output logic        lsu_err_o,
   output logic [31:0] tgt_addr_o,
   output logic [31:0] tgt_wdata_o,
   output logic        tgt_wen_o,
   output logic [3:0]  tgt_bsel_o,
   output logic [2:0]  tgt_sel_o,
   output logic [2:0]  tgt_req_o,
   input  logic [31:0] tgt_rdata0_i,
   input  logic [31:0] tgt_rdata1_i,
   input  logic [31:0] tgt_rdata2_i,
   input  logic [2:0]  tgt_ack_i
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_ERR  = 2'd2;

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]       state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             wen_q, wen_d;
   logic [3:0]       bsel_q, bsel_d;
   logic [2:0]       sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       dec_sel;
   logic             sel_ack;
   logic             in_busy;

   // Fixed priority decode: bmem > uart > clint; all-zero means unmapped.
   always_comb begin
      dec_sel = 3'b000;
      if ((lsu_addr_i & BMEM_MASK) == BMEM_BASE)        dec_sel = 3'b001;
      else if ((lsu_addr_i & UART_MASK) == UART_BASE)   dec_sel = 3'b010;
      else if ((lsu_addr_i & CLINT_MASK) == CLINT_BASE) dec_sel = 3'b100;
   end

   assign in_busy = (state_q == ST_BUSY);
   assign sel_ack = |(sel_q & tgt_ack_i);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wen_d   = wen_q;
      bsel_d  = bsel_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (lsu_req_i) begin
               addr_d  = lsu_addr_i;
               wdata_d = lsu_wdata_i;
               wen_d   = lsu_wen_i;
               bsel_d  = lsu_sel_i;
               sel_d   = dec_sel;
               cnt_d   = '0;
               state_d = (dec_sel != 3'b000) ? ST_BUSY : ST_ERR;
            end
         end
         ST_BUSY: begin
            // A selected ack in the final timeout cycle still completes normally.
            if (sel_ack) begin
               sel_d   = 3'b000;
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               sel_d   = 3'b000;
               state_d = ST_ERR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_ERR: begin
            state_d = ST_IDLE;
         end
         default: begin
            sel_d   = 3'b000;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wen_q   <= 1'b0;
         bsel_q  <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wen_q   <= wen_d;
         bsel_q  <= bsel_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

   assign tgt_addr_o  = addr_q;
   assign tgt_wdata_o = wdata_q;
   assign tgt_wen_o   = wen_q;
   assign tgt_bsel_o  = bsel_q;
   assign tgt_sel_o   = sel_q;

   // Request drops in the ack cycle so the slave never sees a repeated request.
   assign tgt_req_o = in_busy ? (sel_q & ~tgt_ack_i) : 3'b000;
   assign lsu_ack_o = (in_busy && sel_ack) || (state_q == ST_ERR);
   assign lsu_err_o = (state_q == ST_ERR);

   always_comb begin
      lsu_rdata_o = '0;
      if (in_busy && sel_ack) begin
         lsu_rdata_o = ({32{sel_q[0]}} & tgt_rdata0_i)
                     | ({32{sel_q[1]}} & tgt_rdata1_i)
                     | ({32{sel_q[2]}} & tgt_rdata2_i);
      end
   end

endmodule

// File: tb/tb_dbus_periph_router.sv
// Directed bench for dbus_periph_router: reads, writes, unmapped, timeout, stray acks, reset.
module tb_dbus_periph_router;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lsu_req_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_wdata_i;
   logic        lsu_wen_i;
   logic [3:0]  lsu_sel_i;
   logic [31:0] lsu_rdata_o;
   logic        lsu_ack_o;
   logic        lsu_err_o;
   logic [31:0] tgt_addr_o;
   logic [31:0] tgt_wdata_o;
   logic        tgt_wen_o;
   logic [3:0]  tgt_bsel_o;
   logic [2:0]  tgt_sel_o;
   logic [2:0]  tgt_req_o;
   logic [31:0] tgt_rdata0_i;
   logic [31:0] tgt_rdata1_i;
   logic [31:0] tgt_rdata2_i;
   logic [2:0]  tgt_ack_i;

   int passed = 0;
   int total  = 0;

   dbus_periph_router #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
      .lsu_wen_i(lsu_wen_i), .lsu_sel_i(lsu_sel_i),
      .lsu_rdata_o(lsu_rdata_o), .lsu_ack_o(lsu_ack_o), .lsu_err_o(lsu_err_o),
      .tgt_addr_o(tgt_addr_o), .tgt_wdata_o(tgt_wdata_o), .tgt_wen_o(tgt_wen_o),
      .tgt_bsel_o(tgt_bsel_o), .tgt_sel_o(tgt_sel_o), .tgt_req_o(tgt_req_o),
      .tgt_rdata0_i(tgt_rdata0_i), .tgt_rdata1_i(tgt_rdata1_i), .tgt_rdata2_i(tgt_rdata2_i),
      .tgt_ack_i(tgt_ack_i)
   );

   always #5 clk = ~clk;

   // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                        input logic [3:0] sel);
      lsu_req_i   = 1'b1;
      lsu_addr_i  = addr;
      lsu_wen_i   = wen;
      lsu_wdata_i = wdata;
      lsu_sel_i   = sel;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      lsu_req_i = 1'b0; lsu_addr_i = '0; lsu_wdata_i = '0; lsu_wen_i = 1'b0; lsu_sel_i = '0;
      tgt_rdata0_i = 32'h1111_1111; tgt_rdata1_i = 32'h2222_2222; tgt_rdata2_i = 32'h3333_3333;
      tgt_ack_i = 3'b000;
      #1;
      total++;
      if ({lsu_ack_o, lsu_err_o, lsu_rdata_o, tgt_sel_o, tgt_req_o} !== 40'd0) begin
         $display("FAIL reset_outputs: ack=%b err=%b rdata=%h sel=%b req=%b, required all 0",
                  lsu_ack_o, lsu_err_o, lsu_rdata_o, tgt_sel_o, tgt_req_o);
      end else passed++;
      total++;
      if ({tgt_addr_o, tgt_wdata_o, tgt_wen_o, tgt_bsel_o} !== 69'd0) begin
         $display("FAIL reset_regs: addr=%h wdata=%h wen=%b bsel=%b, required all 0",
                  tgt_addr_o, tgt_wdata_o, tgt_wen_o, tgt_bsel_o);
      end else passed++;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_bmem_read();
      issue(32'h0001_0040, 1'b0, 32'h0, 4'hF);
      tick();                       // cycle 1
      lsu_req_i = 1'b0;
      #1;
      total++;
      if (tgt_sel_o !== 3'b001 || tgt_req_o !== 3'b001 || lsu_ack_o !== 1'b0) begin
         $display("FAIL bmem_c1: sel=%b req=%b ack=%b, required 001/001/0", tgt_sel_o, tgt_req_o, lsu_ack_o);
      end else passed++;
      total++;
      if (tgt_addr_o !== 32'h0001_0040 || tgt_wen_o !== 1'b0) begin
         $display("FAIL bmem_addr: addr=%h wen=%b, required 00010040/0", tgt_addr_o, tgt_wen_o);
      end else passed++;
      tick();                       // cycle 2: slave acks
      tgt_ack_i = 3'b001; tgt_rdata0_i = 32'hDEAD_BEEF;
      #1;
      total++;
      if (lsu_ack_o !== 1'b1 || lsu_err_o !== 1'b0 || lsu_rdata_o !== 32'hDEAD_BEEF || tgt_req_o !== 3'b000) begin
         $display("FAIL bmem_c2: ack=%b err=%b rdata=%h req=%b, required 1/0/deadbeef/000",
                  lsu_ack_o, lsu_err_o, lsu_rdata_o, tgt_req_o);
      end else passed++;
      tick();                       // cycle 3
      tgt_ack_i = 3'b000;
      #1;
      total++;
      if (lsu_ack_o !== 1'b0 || tgt_sel_o !== 3'b000 || lsu_rdata_o !== 32'h0) begin
         $display("FAIL bmem_c3: ack=%b sel=%b rdata=%h, required 0/000/0", lsu_ack_o, tgt_sel_o, lsu_rdata_o);
      end else passed++;
   endtask

   task automatic test_uart_write();
      int req_cycles = 0;
      int ack_pulses = 0;
      logic err_seen = 1'b0;
      issue(32'h9000_0004, 1'b1, 32'h41, 4'b0001);
      for (int c = 1; c <= 6; c++) begin
         tick();
         lsu_req_i = 1'b0;
         tgt_ack_i = (c == 4) ? 3'b010 : 3'b000;
         #1;
         if (tgt_req_o == 3'b010) req_cycles++;
         if (lsu_ack_o) ack_pulses++;
         if (lsu_ack_o && lsu_err_o) err_seen = 1'b1;
         if (c == 2) begin
            total++;
            if (tgt_wen_o !== 1'b1 || tgt_wdata_o !== 32'h41 || tgt_bsel_o !== 4'b0001 || tgt_sel_o !== 3'b010) begin
               $display("FAIL uart_fields: wen=%b wdata=%h bsel=%b sel=%b, required 1/41/0001/010",
                        tgt_wen_o, tgt_wdata_o, tgt_bsel_o, tgt_sel_o);
            end else passed++;
         end
      end
      tgt_ack_i = 3'b000;
      total++;
      if (req_cycles !== 3) begin
         $display("FAIL uart_req_len: got %0d cycles, required 3", req_cycles);
      end else passed++;
      total++;
      if (ack_pulses !== 1 || err_seen !== 1'b0) begin
         $display("FAIL uart_ack: pulses=%0d err=%b, required 1/0", ack_pulses, err_seen);
      end else passed++;
   endtask

   task automatic test_unmapped();
      tgt_rdata0_i = 32'h1234_5678;
      issue(32'h5000_0000, 1'b0, 32'h0, 4'hF);
      tick();                       // cycle 1
      lsu_req_i = 1'b0;
      #1;
      total++;
      if (lsu_ack_o !== 1'b1 || lsu_err_o !== 1'b1 || lsu_rdata_o !== 32'h0 ||
          tgt_req_o !== 3'b000 || tgt_sel_o !== 3'b000) begin
         $display("FAIL unmapped_c1: ack=%b err=%b rdata=%h req=%b sel=%b, required 1/1/0/000/000",
                  lsu_ack_o, lsu_err_o, lsu_rdata_o, tgt_req_o, tgt_sel_o);
      end else passed++;
      tick();
      #1;
      total++;
      if (lsu_ack_o !== 1'b0 || lsu_err_o !== 1'b0 || tgt_req_o !== 3'b000) begin
         $display("FAIL unmapped_c2: ack=%b err=%b req=%b, required 0/0/000", lsu_ack_o, lsu_err_o, tgt_req_o);
      end else passed++;
   endtask

   task automatic test_timeout();
      int req_cycles = 0;
      issue(32'h0200_0010, 1'b0, 32'h0, 4'hF);
      for (int c = 1; c <= 4; c++) begin
         tick();
         lsu_req_i = 1'b0;
         #1;
         if (tgt_req_o == 3'b100 && !lsu_ack_o) req_cycles++;
      end
      total++;
      if (req_cycles !== 4) begin
         $display("FAIL timeout_req_len: got %0d cycles, required 4", req_cycles);
      end else passed++;
      tick();                       // cycle 5: error response
      #1;
      total++;
      if (lsu_ack_o !== 1'b1 || lsu_err_o !== 1'b1 || lsu_rdata_o !== 32'h0 || tgt_req_o !== 3'b000) begin
         $display("FAIL timeout_err: ack=%b err=%b rdata=%h req=%b, required 1/1/0/000",
                  lsu_ack_o, lsu_err_o, lsu_rdata_o, tgt_req_o);
      end else passed++;
      tick();
      #1;
      total++;
      if (lsu_ack_o !== 1'b0) begin
         $display("FAIL timeout_after: ack=%b, required 0", lsu_ack_o);
      end else passed++;
      // Normal bmem read afterwards
      issue(32'h0001_0000, 1'b0, 32'h0, 4'hF);
      tick();
      lsu_req_i = 1'b0;
      tick();
      tgt_ack_i = 3'b001; tgt_rdata0_i = 32'h0BAD_F00D;
      #1;
      total++;
      if (lsu_ack_o !== 1'b1 || lsu_err_o !== 1'b0 || lsu_rdata_o !== 32'h0BAD_F00D) begin
         $display("FAIL timeout_recover: ack=%b err=%b rdata=%h, required 1/0/0badf00d",
                  lsu_ack_o, lsu_err_o, lsu_rdata_o);
      end else passed++;
      tick();
      tgt_ack_i = 3'b000;
   endtask

   task automatic test_ack_beats_timeout();
      tgt_rdata2_i = 32'hC11A_0001;
      issue(32'h0200_0004, 1'b0, 32'h0, 4'hF);
      for (int c = 1; c <= 3; c++) begin
         tick();
         lsu_req_i = 1'b0;
      end
      tick();                       // cycle 4: last cycle before timeout
      tgt_ack_i = 3'b100;
      #1;
      total++;
      if (lsu_ack_o !== 1'b1 || lsu_err_o !== 1'b0 || lsu_rdata_o !== 32'hC11A_0001) begin
         $display("FAIL ack_vs_timeout: ack=%b err=%b rdata=%h, required 1/0/c11a0001",
                  lsu_ack_o, lsu_err_o, lsu_rdata_o);
      end else passed++;
      tick();
      tgt_ack_i = 3'b000;
      #1;
      total++;
      if (lsu_ack_o !== 1'b0 || lsu_err_o !== 1'b0) begin
         $display("FAIL ack_vs_timeout_after: ack=%b err=%b, required 0/0", lsu_ack_o, lsu_err_o);
      end else passed++;
   endtask

   task automatic test_stray_acks();
      tgt_ack_i = 3'b010;           // stray ack while idle
      #1;
      total++;
      if (lsu_ack_o !== 1'b0 || tgt_req_o !== 3'b000) begin
         $display("FAIL stray_idle: ack=%b req=%b, required 0/000", lsu_ack_o, tgt_req_o);
      end else passed++;
      tick();
      tgt_ack_i = 3'b000;
      tgt_rdata1_i = 32'h5555_AAAA;
      issue(32'h0001_0100, 1'b0, 32'h0, 4'hF);
      tick();                       // cycle 1: wrong target acks
      lsu_req_i = 1'b0;
      tgt_ack_i = 3'b010;
      #1;
      total++;
      if (lsu_ack_o !== 1'b0 || tgt_req_o !== 3'b001) begin
         $display("FAIL stray_busy: ack=%b req=%b, required 0/001", lsu_ack_o, tgt_req_o);
      end else passed++;
      tick();
      tgt_ack_i = 3'b000;
      #1;
      total++;
      if (lsu_ack_o !== 1'b0 || tgt_req_o !== 3'b001) begin
         $display("FAIL stray_wait: ack=%b req=%b, required 0/001", lsu_ack_o, tgt_req_o);
      end else passed++;
      tick();
      tgt_ack_i = 3'b011; tgt_rdata0_i = 32'hCAFE_F00D;
      #1;
      total++;
      if (lsu_ack_o !== 1'b1 || lsu_rdata_o !== 32'hCAFE_F00D || lsu_err_o !== 1'b0) begin
         $display("FAIL stray_done: ack=%b rdata=%h err=%b, required 1/cafef00d/0",
                  lsu_ack_o, lsu_rdata_o, lsu_err_o);
      end else passed++;
      tick();
      tgt_ack_i = 3'b000;
   endtask

   task automatic test_reset_busy();
      int acks = 0;
      issue(32'h0001_0200, 1'b1, 32'h7777_0000, 4'b1100);
      tick();                       // cycle 1: in BUSY
      lsu_req_i = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if ({lsu_ack_o, lsu_err_o, lsu_rdata_o, tgt_sel_o, tgt_req_o} !== 40'd0 ||
          {tgt_addr_o, tgt_wdata_o, tgt_wen_o, tgt_bsel_o} !== 69'd0) begin
         $display("FAIL reset_busy: sel=%b req=%b addr=%h wen=%b ack=%b, required all 0",
                  tgt_sel_o, tgt_req_o, tgt_addr_o, tgt_wen_o, lsu_ack_o);
      end else passed++;
      tick();
      rst_n = 1'b1;
      tgt_ack_i = 3'b001;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (lsu_ack_o) acks++;
         tick();
         tgt_ack_i = 3'b000;
      end
      total++;
      if (acks !== 0) begin
         $display("FAIL reset_no_ack: got %0d acks, required 0", acks);
      end else passed++;
      issue(32'h0001_0008, 1'b0, 32'h0, 4'hF);
      tick();
      lsu_req_i = 1'b0;
      tick();
      tgt_ack_i = 3'b001; tgt_rdata0_i = 32'hFEED_0002;
      #1;
      total++;
      if (lsu_ack_o !== 1'b1 || lsu_err_o !== 1'b0 || lsu_rdata_o !== 32'hFEED_0002) begin
         $display("FAIL reset_new_read: ack=%b err=%b rdata=%h, required 1/0/feed0002",
                  lsu_ack_o, lsu_err_o, lsu_rdata_o);
      end else passed++;
      tick();
      tgt_ack_i = 3'b000;
   endtask

   initial begin
      test_reset();
      test_bmem_read();
      test_uart_write();
      test_unmapped();
      test_timeout();
      test_ack_beats_timeout();
      test_stray_acks();
      test_reset_busy();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
